// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit in front of a byte-addressed,
// single-port RAM. A request is checked and latched in IDLE. A legal request
// then gets exactly one ACCESS cycle. Its response is held in RESP until the
// core takes it. An illegal request goes straight to RESP with the error flag
// set and never touches the RAM.
module mem_lsu #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_din_o,
  input  logic [31:0] mem_dout_i
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [2:0]  req_nbytes;
  logic [32:0] req_end;
  logic        req_illegal;
  logic [31:0] lane;
  logic [31:0] load_data;

  // Legality of the incoming request. The end address is computed 33 bits
  // wide so that addresses near 2^32 cannot wrap around into range.
  always_comb begin
    case (req_size_i)
      SZ_BYTE: req_nbytes = 3'd1;
      SZ_HALF: req_nbytes = 3'd2;
      default: req_nbytes = 3'd4;
    endcase
    req_end     = {1'b0, req_addr_i} + {30'b0, req_nbytes};
    req_illegal = (req_size_i == 2'b11)
                | ((req_size_i == SZ_HALF) && (req_addr_i[1:0] == 2'b11))
                | ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00))
                | (req_end > 33'(MEM_BYTES));
  end

  // Select the addressed lane of the RAM word and extend it to 32 bits.
  always_comb begin
    lane = mem_dout_i >> {addr_q[1:0], 3'b000};
    case (size_q)
      SZ_BYTE: load_data = uns_q ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      SZ_HALF: load_data = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  // Next-state, request latching and all outputs, decoded from the current state.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_rdata_o = 32'h0;
    resp_err_o   = 1'b0;
    mem_en_o     = 1'b0;
    mem_we_o     = 4'b0000;
    mem_addr_o   = 32'h0;
    mem_din_o    = 32'h0;

    case (state_q)
      S_IDLE: begin
        // rstn_i gates ready so it is low for the whole reset period.
        req_ready_o = rstn_i;
        if (req_valid_i && req_ready_o) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          rdata_d = 32'h0;
          err_d   = req_illegal;
          state_d = req_illegal ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_en_o = 1'b1;
        if (we_q) begin
          // Stores present the exact byte address; the write code selects the bytes.
          mem_addr_o = addr_q;
          mem_din_o  = wdata_q;
          case (size_q)
            SZ_BYTE: mem_we_o = 4'b0001;
            SZ_HALF: mem_we_o = 4'b0011;
            default: mem_we_o = 4'b1111;
          endcase
          rdata_d = 32'h0;
        end else begin
          // Loads read the whole aligned word and extract the lane locally.
          mem_addr_o = {addr_q[31:2], 2'b00};
          rdata_d    = load_data;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        resp_rdata_o = rdata_q;
        resp_err_o   = err_q;
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers. The reset is asynchronous, so an access or
  // response in flight is dropped as soon as rstn_i falls.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed, table-driven bench for mem_lsu with a byte-array RAM model.
module tb_mem_lsu;
  localparam int MB = 4096;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_din_o;
  logic [31:0] mem_dout_i;

  int checks = 0;
  int failures = 0;
  int idle_viol = 0;

  always #5 clk = ~clk;

  mem_lsu #(.MEM_BYTES(MB)) dut (
    .clk(clk), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_din_o(mem_din_o), .mem_dout_i(mem_dout_i)
  );

  // RAM model: little-endian bytes, combinational aligned-word read, write at the clock edge.
  logic [7:0]  ram [0:MB-1];
  logic        ram_ready = 1'b0;
  logic [31:0] rd_base;
  assign rd_base = {mem_addr_o[31:2], 2'b00};

  always_comb begin
    mem_dout_i = 32'h0;
    if (mem_en_o && rd_base <= 32'(MB - 4))
      mem_dout_i = {ram[{rd_base[11:2], 2'd3}], ram[{rd_base[11:2], 2'd2}],
                    ram[{rd_base[11:2], 2'd1}], ram[{rd_base[11:2], 2'd0}]};
  end

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < MB; i++) ram[i] <= 8'h00;
    end else if (mem_en_o) begin
      for (int k = 0; k < 4; k++)
        if (mem_we_o[k] && (mem_addr_o + 32'(k)) < 32'(MB))
          ram[mem_addr_o[11:0] + 12'(k)] <= mem_din_o[8*k +: 8];
    end
  end

  // Response data and error must read zero whenever no response is offered.
  always @(negedge clk) begin
    if (!resp_valid_o && (resp_rdata_o != 32'h0 || resp_err_o)) idle_viol++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_mwe;
  } vec_t;

  vec_t vecs [23];

  // One complete transaction; reports what was seen during ACCESS and in RESP.
  task automatic run_req(input vec_t v, output logic [31:0] rd, output logic er,
                         output logic [31:0] ma, output logic [3:0] mw, output logic [31:0] md,
                         output int en_cnt, output int lat, output logic tmo);
    req_we_i = v.we; req_size_i = v.size; req_unsigned_i = v.uns;
    req_addr_i = v.addr; req_wdata_i = v.wdata; req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    en_cnt = 0; lat = 0; tmo = 1'b1; ma = 32'h0; mw = 4'h0; md = 32'h0;
    for (int n = 0; n < 10; n++) begin
      if (mem_en_o) begin en_cnt++; ma = mem_addr_o; mw = mem_we_o; md = mem_din_o; end
      if (resp_valid_o) begin tmo = 1'b0; lat = n; break; end
      @(posedge clk); #1;
    end
    rd = resp_rdata_o; er = resp_err_o;
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
  endtask

  logic [31:0] g_rd, g_ma, g_md;
  logic [3:0]  g_mw;
  logic        g_er, g_tmo;
  int          g_en, g_lat;
  vec_t        tv;

  initial begin
    //           we    size   uns   addr          wdata         exp_rdata     err   maddr         mwe
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0, 32'h10,  4'b1111};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 32'h10,  4'b0000};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h21,       32'hFFFFFF80, 32'h0,        1'b0, 32'h21,  4'b0001};
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h21,       32'h0,        32'hFFFFFF80, 1'b0, 32'h20,  4'b0000};
    vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h21,       32'h0,        32'h00000080, 1'b0, 32'h20,  4'b0000};
    vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h20,       32'h0,        32'h00008000, 1'b0, 32'h20,  4'b0000};
    vecs[6]  = '{1'b1, 2'b01, 1'b0, 32'h32,       32'h0000A55A, 32'h0,        1'b0, 32'h32,  4'b0011};
    vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h32,       32'h0,        32'hFFFFA55A, 1'b0, 32'h30,  4'b0000};
    vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'h32,       32'h0,        32'h0000A55A, 1'b0, 32'h30,  4'b0000};
    vecs[9]  = '{1'b0, 2'b00, 1'b0, 32'h13,       32'h0,        32'hFFFFFFDE, 1'b0, 32'h10,  4'b0000};
    vecs[10] = '{1'b0, 2'b01, 1'b1, 32'h11,       32'h0,        32'h0000ADBE, 1'b0, 32'h10,  4'b0000};
    vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h13,       32'h0,        32'h0,        1'b1, 32'h0,   4'b0000};
    vecs[12] = '{1'b0, 2'b01, 1'b0, 32'h07,       32'h0,        32'h0,        1'b1, 32'h0,   4'b0000};
    vecs[13] = '{1'b0, 2'b11, 1'b0, 32'h00,       32'h0,        32'h0,        1'b1, 32'h0,   4'b0000};
    vecs[14] = '{1'b0, 2'b00, 1'b0, 32'h1000,     32'h0,        32'h0,        1'b1, 32'h0,   4'b0000};
    vecs[15] = '{1'b0, 2'b00, 1'b1, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1, 32'h0,   4'b0000};
    vecs[16] = '{1'b1, 2'b11, 1'b0, 32'h10,       32'h0BADBAD0, 32'h0,        1'b1, 32'h0,   4'b0000};
    vecs[17] = '{1'b1, 2'b10, 1'b0, 32'h1000,     32'h77777777, 32'h0,        1'b1, 32'h0,   4'b0000};
    vecs[18] = '{1'b1, 2'b10, 1'b0, 32'hFFC,      32'h12345678, 32'h0,        1'b0, 32'hFFC, 4'b1111};
    vecs[19] = '{1'b0, 2'b10, 1'b0, 32'hFFC,      32'h0,        32'h12345678, 1'b0, 32'hFFC, 4'b0000};
    vecs[20] = '{1'b0, 2'b01, 1'b0, 32'hFFE,      32'h0,        32'h00001234, 1'b0, 32'hFFC, 4'b0000};
    vecs[21] = '{1'b0, 2'b00, 1'b1, 32'hFFF,      32'h0,        32'h00000012, 1'b0, 32'hFFC, 4'b0000};
    vecs[22] = '{1'b0, 2'b10, 1'b1, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 32'h10,  4'b0000};

    rstn_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0; resp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ram_ready = 1'b1;
    check("rst_req_ready",  32'(req_ready_o), 32'h0);
    check("rst_resp_valid", 32'(resp_valid_o), 32'h0);
    check("rst_resp_err",   32'(resp_err_o), 32'h0);
    check("rst_resp_rdata", resp_rdata_o, 32'h0);
    check("rst_mem_en",     32'(mem_en_o), 32'h0);
    check("rst_mem_we",     32'(mem_we_o), 32'h0);
    check("rst_mem_addr",   mem_addr_o, 32'h0);
    check("rst_mem_din",    mem_din_o, 32'h0);
    rstn_i = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(req_ready_o), 32'h1);

    // Table-driven transactions.
    for (int i = 0; i < 23; i++) begin
      tv = vecs[i];
      check($sformatf("v%0d_ready", i), 32'(req_ready_o), 32'h1);
      run_req(tv, g_rd, g_er, g_ma, g_mw, g_md, g_en, g_lat, g_tmo);
      $display("txn %0d we=%0d size=%0d uns=%0d addr=0x%08h rdata=0x%08h err=%0d",
               i, tv.we, tv.size, tv.uns, tv.addr, g_rd, g_er);
      check($sformatf("v%0d_timeout", i), 32'(g_tmo), 32'h0);
      check($sformatf("v%0d_rdata", i), g_rd, tv.exp_rdata);
      check($sformatf("v%0d_err", i), 32'(g_er), 32'(tv.exp_err));
      check($sformatf("v%0d_en_cycles", i), 32'(g_en), tv.exp_err ? 32'h0 : 32'h1);
      if (!tv.exp_err) begin
        check($sformatf("v%0d_mem_addr", i), g_ma, tv.exp_maddr);
        check($sformatf("v%0d_mem_we", i), 32'(g_mw), 32'(tv.exp_mwe));
        check($sformatf("v%0d_latency", i), 32'(g_lat), 32'h1);
        if (tv.we) check($sformatf("v%0d_mem_din", i), g_md, tv.wdata);
      end
    end

    // Backpressure: response held while a second request is waved at the LSU.
    req_we_i = 1'b0; req_size_i = 2'b10; req_unsigned_i = 1'b0;
    req_addr_i = 32'h10; req_wdata_i = 32'h0; req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_we_i = 1'b1; req_wdata_i = 32'hCAFEF00D;
    check("bp_access_en", 32'(mem_en_o), 32'h1);
    check("bp_access_we", 32'(mem_we_o), 32'h0);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_valid", c), 32'(resp_valid_o), 32'h1);
      check($sformatf("bp%0d_rdata", c), resp_rdata_o, 32'hDEADBEEF);
      check($sformatf("bp%0d_ready", c), 32'(req_ready_o), 32'h0);
      check($sformatf("bp%0d_mem_en", c), 32'(mem_en_o), 32'h0);
      @(posedge clk); #1;
    end
    $display("txn bp load addr=0x00000010 rdata=0x%08h err=%0d (held 5 cycles)", resp_rdata_o, resp_err_o);
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
    check("bp_hs_valid", 32'(resp_valid_o), 32'h0);
    check("bp_hs_no_accept", 32'(mem_en_o), 32'h0);
    check("bp_hs_ready", 32'(req_ready_o), 32'h1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("bp2_en", 32'(mem_en_o), 32'h1);
    check("bp2_we", 32'(mem_we_o), 32'hF);
    check("bp2_din", mem_din_o, 32'hCAFEF00D);
    @(posedge clk); #1;
    check("bp2_resp", 32'(resp_valid_o), 32'h1);
    check("bp2_err", 32'(resp_err_o), 32'h0);
    $display("txn bp2 store addr=0x00000010 wdata=0xcafef00d err=%0d", resp_err_o);
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
    tv = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 32'h10, 4'b0000};
    run_req(tv, g_rd, g_er, g_ma, g_mw, g_md, g_en, g_lat, g_tmo);
    $display("txn bp3 load addr=0x00000010 rdata=0x%08h err=%0d", g_rd, g_er);
    check("bp3_timeout", 32'(g_tmo), 32'h0);
    check("bp3_rdata", g_rd, 32'hCAFEF00D);

    // Reset in the middle of a store's ACCESS cycle.
    tv = '{1'b1, 2'b10, 1'b0, 32'h40, 32'h55AA55AA, 32'h0, 1'b0, 32'h40, 4'b1111};
    run_req(tv, g_rd, g_er, g_ma, g_mw, g_md, g_en, g_lat, g_tmo);
    $display("txn rs0 store addr=0x00000040 wdata=0x55aa55aa err=%0d", g_er);
    check("rs0_timeout", 32'(g_tmo), 32'h0);
    req_we_i = 1'b1; req_size_i = 2'b10; req_addr_i = 32'h40;
    req_wdata_i = 32'h99999999; req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("rs_in_access", 32'(mem_en_o), 32'h1);
    #2;
    rstn_i = 1'b0;
    #1;
    $display("txn rs1 store addr=0x00000040 wdata=0x99999999 aborted by reset");
    check("rs_mem_en",     32'(mem_en_o), 32'h0);
    check("rs_mem_we",     32'(mem_we_o), 32'h0);
    check("rs_mem_addr",   mem_addr_o, 32'h0);
    check("rs_mem_din",    mem_din_o, 32'h0);
    check("rs_resp_valid", 32'(resp_valid_o), 32'h0);
    check("rs_resp_rdata", resp_rdata_o, 32'h0);
    check("rs_req_ready",  32'(req_ready_o), 32'h0);
    @(posedge clk); #1;
    rstn_i = 1'b1;
    @(posedge clk); #1;
    check("rs_ready_after", 32'(req_ready_o), 32'h1);
    check("rs_no_resp",     32'(resp_valid_o), 32'h0);
    tv = '{1'b0, 2'b10, 1'b1, 32'h40, 32'h0, 32'h0, 1'b0, 32'h40, 4'b0000};
    run_req(tv, g_rd, g_er, g_ma, g_mw, g_md, g_en, g_lat, g_tmo);
    $display("txn rs2 load addr=0x00000040 rdata=0x%08h err=%0d", g_rd, g_er);
    check("rs2_timeout", 32'(g_tmo), 32'h0);
    check("rs2_rdata", g_rd, 32'h55AA55AA);

    check("idle_rdata_zero", 32'(idle_viol), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
